if_fetch_stage: RTL

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the PC and the IF/ID pipeline register, and issues requests to instruction memory over a valid/ready request and in-order response interface. A 2-entry fetch buffer absorbs responses while the hazard unit asserts stall. The stage pre-decodes rs1, rs2 and the store flag from the IF/ID instruction, which the downstream forwarding/hazard unit consumes for load-use stall detection.

---
 rtl/rv_pkg.sv | 36 +++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/if_fetch_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I constants, fetch-buffer entry type and the IF/ID pre-decode helper.
package rv_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [6:0]  OPCODE_STORE = 7'b0100011;
  localparam logic [6:0]  OPCODE_LOAD  = 7'b0000011;

  localparam int OPCODE_W = 7;
  localparam int REG_W    = 5;
  localparam int RS1_LSB  = 15;
  localparam int RS2_LSB  = 20;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             mem_write;
  } predecode_t;

  // Fields are forced to zero for bubbles so hazard logic never matches a stale register.
  function automatic predecode_t predecode(input logic valid, input logic [31:0] instr);
    predecode_t p;
    p = '0;
    if (valid) begin
      p.rs1       = instr[RS1_LSB +: REG_W];
      p.rs2       = instr[RS2_LSB +: REG_W];
      p.mem_write = (instr[OPCODE_W-1:0] == OPCODE_STORE);
    end
    return p;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with flush; buffers fetched
// instructions while the decode stage is stalled.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = next_ptr(wr_q);
      end
      if (pop) begin
        rd_d = next_ptr(rd_q);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign pop_data = mem_q[rd_q];
  assign count    = cnt_q;
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));

  a_no_underflow : assert property (@(posedge clk) disable iff (rst) pop |-> !empty);

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues credit-limited imem requests,
// buffers in-order responses and drives the IF/ID register with pre-decoded fields.
module if_fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc_if_id_out,
  output logic [31:0] instr_if_id_out,
  output logic        valid_if_id_out,
  output logic [4:0]  rs1_id_if_id_out,
  output logic [4:0]  rs2_id_if_id_out,
  output logic        Memwrite_if_id_out
);

  localparam int               CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [31:0]      sq_mem_q [FIFO_DEPTH];
  logic [31:0]      sq_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] sq_wr_q, sq_wr_d;
  logic [PTR_W-1:0] sq_rd_q, sq_rd_d;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic [31:0]      if_instr_q, if_instr_d;
  predecode_t       pd_q, pd_d;

  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_in, fifo_head;
  logic [CNT_W:0]   credit_used;
  logic             req_fire, rsp_keep;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // imem handshake: a request transfers on a cycle where valid && ready are both high;
  // valid never depends on ready, and valid/addr stay stable while ready is low.
  // Responses carry no ready and return one per cycle in request order.
  assign credit_used    = {1'b0, out_q} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < CREDIT_MAX);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Same-cycle responses during a redirect belong to the old stream.
  assign rsp_keep  = imem_rsp_valid && !redirect_valid && (drop_q == '0);
  assign fifo_push = rsp_keep;
  assign fifo_in   = '{pc: sq_mem_q[sq_rd_q], instr: imem_rsp_data};
  assign fifo_pop  = !redirect_valid && !stall && !fifo_empty;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_data(fifo_in),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    pc_d       = pc_q;
    out_d      = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    drop_d     = drop_q;
    sq_mem_d   = sq_mem_q;
    sq_wr_d    = sq_wr_q;
    sq_rd_d    = sq_rd_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    pd_d       = pd_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc & ~32'h3;
      drop_d  = out_q - CNT_W'(imem_rsp_valid);
      sq_wr_d = '0;
      sq_rd_d = '0;
    end else begin
      if (req_fire) begin
        pc_d              = pc_q + 32'd4;
        sq_mem_d[sq_wr_q] = pc_q;
        sq_wr_d           = next_ptr(sq_wr_q);
      end
      if (rsp_keep) begin
        sq_rd_d = next_ptr(sq_rd_q);
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end

    if (redirect_valid || (!stall && fifo_empty)) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      pd_d       = '0;
    end else if (!stall) begin
      if_valid_d = 1'b1;
      if_pc_d    = fifo_head.pc;
      if_instr_d = fifo_head.instr;
      pd_d       = predecode(1'b1, fifo_head.instr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      sq_mem_q   <= '{default: '0};
      sq_wr_q    <= '0;
      sq_rd_q    <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      pd_q       <= '0;
    end else begin
      pc_q       <= pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      sq_mem_q   <= sq_mem_d;
      sq_wr_q    <= sq_wr_d;
      sq_rd_q    <= sq_rd_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      pd_q       <= pd_d;
    end
  end

  assign pc_if_id_out       = if_pc_q;
  assign instr_if_id_out    = if_instr_q;
  assign valid_if_id_out    = if_valid_q;
  assign rs1_id_if_id_out   = pd_q.rs1;
  assign rs2_id_if_id_out   = pd_q.rs2;
  assign Memwrite_if_id_out = pd_q.mem_write;

  a_no_overflow  : assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));
  a_rsp_expected : assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (out_q != '0));

endmodule
